// File: rtl/cpu_lsu.sv
// cpu_lsu: load/store stage sitting directly after exec.
// It accepts one memory request at a time over a valid/ready handshake.
// It owns the data memory d_mem, which is written with byte enables and read synchronously.
// It returns extended load data, or a no-writeback store acknowledge, as a one-cycle pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, a misaligned
// halfword/word access faults. When it is undefined, the low address bits are masked.
module cpu_lsu #(
    parameter int DMEM_WORDS = 1024,
    parameter int DMEM_AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_valid,
    output logic        e_ready,
    input  logic        e_is_store,
    input  logic [2:0]  e_funct3,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_wdata,
    input  logic [4:0]  e_rd,
    output logic        m_valid,
    output logic        m_rd_we,
    output logic [4:0]  m_rd,
    output logic [31:0] m_rdata,
    output logic        m_fault,
    output logic [31:0] m_badaddr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0]        d_mem [DMEM_WORDS];

    state_t             state_q;
    logic               e_ready_q;
    logic               m_valid_q;
    logic               m_rd_we_q;
    logic               m_fault_q;
    logic [4:0]         m_rd_q;
    logic [31:0]        m_rdata_q;
    logic [31:0]        m_badaddr_q;
    logic [DMEM_AW+1:0] addr_q;
    logic [2:0]         f3_q;
    logic [4:0]         rd_q;

    logic               accept_s;
    logic               misalign_s;
    logic               st_we_s;
    logic [3:0]         st_be_s;
    logic [31:0]        st_data_s;
    logic [DMEM_AW-1:0] st_idx_s;
    logic [DMEM_AW-1:0] ld_idx_s;

    // Byte-lane enables for a store. funct3[1:0]=11 behaves as a word.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data so that every enabled lane sees the correct bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Select a byte or halfword from the word and extend it. Unlisted funct3 codes read the whole word.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Flag halfword accesses with addr[0] set, and word accesses with addr[1:0] nonzero.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (e_funct3[1]) begin
            misalign_s = (e_addr[1:0] != 2'b00);
        end else if (e_funct3[0]) begin
            misalign_s = e_addr[0];
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
    end

    // Handshake, store-side decode and word indices. Upper address bits are dropped, so addresses wrap.
    always_comb begin
        accept_s  = e_valid && e_ready_q;
        st_we_s   = accept_s && e_is_store && !misalign_s;
        st_be_s   = store_be(e_funct3[1:0], e_addr[1:0]);
        st_data_s = store_lanes(e_funct3[1:0], e_wdata);
        st_idx_s  = e_addr[DMEM_AW+1:2];
        ld_idx_s  = addr_q[DMEM_AW+1:2];
    end

    // Data memory write port. Stores commit on the accepting edge, and the contents are never reset.
    always_ff @(posedge clk) begin
        if (rst_n && st_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be_s[i]) begin
                    d_mem[st_idx_s][8*i +: 8] <= st_data_s[8*i +: 8];
                end
            end
        end
    end

    // Request FSM. It also holds the response registers, which are pulsed for a single cycle in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            e_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_rd_we_q   <= 1'b0;
            m_fault_q   <= 1'b0;
            m_rd_q      <= 5'd0;
            m_rdata_q   <= 32'd0;
            m_badaddr_q <= 32'd0;
            addr_q      <= {(DMEM_AW+2){1'b0}};
            f3_q        <= 3'd0;
            rd_q        <= 5'd0;
        end else begin
            m_valid_q <= 1'b0;
            m_rd_we_q <= 1'b0;
            m_fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        addr_q    <= e_addr[DMEM_AW+1:0];
                        f3_q      <= e_funct3;
                        rd_q      <= e_rd;
                        e_ready_q <= 1'b0;
                        if (misalign_s) begin
                            state_q     <= S_RESP;
                            m_valid_q   <= 1'b1;
                            m_fault_q   <= 1'b1;
                            m_badaddr_q <= e_addr;
                            m_rd_q      <= e_rd;
                            m_rdata_q   <= 32'd0;
                        end else if (e_is_store) begin
                            state_q   <= S_RESP;
                            m_valid_q <= 1'b1;
                            m_rd_q    <= e_rd;
                            m_rdata_q <= 32'd0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    state_q   <= S_RESP;
                    m_valid_q <= 1'b1;
                    m_rd_q    <= rd_q;
                    m_rd_we_q <= (rd_q != 5'd0);
                    m_rdata_q <= load_extract(d_mem[ld_idx_s], addr_q[1:0], f3_q);
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    e_ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    e_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign e_ready   = e_ready_q;
    assign m_valid   = m_valid_q;
    assign m_rd_we   = m_rd_we_q;
    assign m_fault   = m_fault_q;
    assign m_rd      = m_rd_q;
    assign m_rdata   = m_rdata_q;
    assign m_badaddr = m_badaddr_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: a vector table plus hand-written reset/handshake sequences.
// Expectations follow the LSU_MISALIGN_TRAP_EN setting of the build.
module tb_cpu_lsu;

    logic        clk;
    logic        rst_n;
    logic        e_valid;
    logic        e_ready;
    logic        e_is_store;
    logic [2:0]  e_funct3;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    logic        m_valid;
    logic        m_rd_we;
    logic [4:0]  m_rd;
    logic [31:0] m_rdata;
    logic        m_fault;
    logic [31:0] m_badaddr;

    int errors = 0;
    int checks = 0;

    cpu_lsu #(.DMEM_WORDS(1024), .DMEM_AW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e_valid   (e_valid),
        .e_ready   (e_ready),
        .e_is_store(e_is_store),
        .e_funct3  (e_funct3),
        .e_addr    (e_addr),
        .e_wdata   (e_wdata),
        .e_rd      (e_rd),
        .m_valid   (m_valid),
        .m_rd_we   (m_rd_we),
        .m_rd      (m_rd),
        .m_rdata   (m_rdata),
        .m_fault   (m_fault),
        .m_badaddr (m_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          lat;
        logic [31:0] rdata;
        logic        we;
        logic        flt;
        logic        chk_bad;
        logic [31:0] bad;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [4:0] rd, input int lat,
                                input logic [31:0] rdata, input logic we, input logic flt,
                                input logic chk_bad, input logic [31:0] bad);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.lat = lat;
        v.rdata = rdata; v.we = we; v.flt = flt; v.chk_bad = chk_bad; v.bad = bad;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its response. lat counts the cycles from the accepting edge to m_valid.
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd, output int lat);
        int guard;
        guard = 0;
        while (!e_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        e_valid = 1'b1; e_is_store = st; e_funct3 = f3; e_addr = a; e_wdata = wd; e_rd = rd;
        @(posedge clk); #1;
        e_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;
        rst_n = 1'b0; e_valid = 1'b0; e_is_store = 1'b0; e_funct3 = 3'd0;
        e_addr = 32'd0; e_wdata = 32'd0; e_rd = 5'd0;

        // Preload stores, then loads of every width and sign
        add(1'b1, 3'b010, 32'h10, 32'h80F17F82, 5'd3, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 3'b010, 32'h20, 32'h11223344, 5'd0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b010, 32'h10, 32'h0, 5'd5,  2, 32'h80F17F82, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b000, 32'h10, 32'h0, 5'd6,  2, 32'hFFFFFF82, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b100, 32'h10, 32'h0, 5'd7,  2, 32'h00000082, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b001, 32'h12, 32'h0, 5'd8,  2, 32'hFFFF80F1, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b101, 32'h12, 32'h0, 5'd9,  2, 32'h000080F1, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b000, 32'h11, 32'h0, 5'd10, 2, 32'h0000007F, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b000, 32'h13, 32'h0, 5'd10, 2, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b001, 32'h10, 32'h0, 5'd11, 2, 32'h00007F82, 1'b1, 1'b0, 1'b0, 32'h0);
        // Byte and halfword stores merge into the existing word
        add(1'b1, 3'b000, 32'h21, 32'hDEADBEAB, 5'd4, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b010, 32'h20, 32'h0, 5'd12, 2, 32'h1122AB44, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b1, 3'b001, 32'h22, 32'h1234CAFE, 5'd1, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b010, 32'h20, 32'h0, 5'd12, 2, 32'hCAFEAB44, 1'b1, 1'b0, 1'b0, 32'h0);
        // rd=0 gives no writeback; the address wraps; funct3 011 behaves as LW
        add(1'b0, 3'b010, 32'h10,   32'h0, 5'd0,  2, 32'h80F17F82, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b010, 32'h1010, 32'h0, 5'd14, 2, 32'h80F17F82, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 3'b011, 32'h20,   32'h0, 5'd15, 2, 32'hCAFEAB44, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(1'b0, 3'b010, 32'h13, 32'h0, 5'd13, 1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h13);
        add(1'b1, 3'b001, 32'h11, 32'h00005555, 5'd2, 1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h11);
        add(1'b0, 3'b010, 32'h10, 32'h0, 5'd16, 2, 32'h80F17F82, 1'b1, 1'b0, 1'b0, 32'h0);
`else
        add(1'b0, 3'b010, 32'h13, 32'h0, 5'd13, 2, 32'h80F17F82, 1'b1, 1'b0, 1'b1, 32'h0);
        add(1'b1, 3'b001, 32'h11, 32'h00005555, 5'd2, 1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 3'b010, 32'h10, 32'h0, 5'd16, 2, 32'h80F15555, 1'b1, 1'b0, 1'b1, 32'h0);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_e_ready",   32'(e_ready),  32'd1);
        chk("rst_m_valid",   32'(m_valid),  32'd0);
        chk("rst_m_rd_we",   32'(m_rd_we),  32'd0);
        chk("rst_m_rd",      32'(m_rd),     32'd0);
        chk("rst_m_rdata",   m_rdata,       32'd0);
        chk("rst_m_fault",   32'(m_fault),  32'd0);
        chk("rst_m_badaddr", m_badaddr,     32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat),       32'(vecs[i].lat));
            chk($sformatf("v%0d_rdata", i),   m_rdata,        vecs[i].rdata);
            chk($sformatf("v%0d_rd_we", i),   32'(m_rd_we),   32'(vecs[i].we));
            chk($sformatf("v%0d_rd", i),      32'(m_rd),      32'(vecs[i].rd));
            chk($sformatf("v%0d_fault", i),   32'(m_fault),   32'(vecs[i].flt));
            if (vecs[i].chk_bad) begin
                chk($sformatf("v%0d_badaddr", i), m_badaddr, vecs[i].bad);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse_end", i), 32'(m_valid), 32'd0);
            chk($sformatf("v%0d_we_low", i),    32'(m_rd_we), 32'd0);
            chk($sformatf("v%0d_fault_low", i), 32'(m_fault), 32'd0);
            chk($sformatf("v%0d_rdata_hold", i), m_rdata,     vecs[i].rdata);
            chk($sformatf("v%0d_rd_hold", i),   32'(m_rd),    32'(vecs[i].rd));
        end

        // Reset while in LOAD aborts the load with no response
        e_valid = 1'b1; e_is_store = 1'b0; e_funct3 = 3'b010; e_addr = 32'h10; e_rd = 5'd5;
        @(posedge clk); #1;
        e_valid = 1'b0;
        chk("abort_in_load", 32'(e_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_e_ready", 32'(e_ready), 32'd1);
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        chk("abort_m_rdata", m_rdata,      32'd0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (m_valid) seen = 1'b1;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);

        // A request held during RESP is taken only in the following IDLE cycle
        e_valid = 1'b1; e_is_store = 1'b1; e_funct3 = 3'b010; e_addr = 32'h30;
        e_wdata = 32'h0BADF00D; e_rd = 5'd9;
        @(posedge clk); #1;
        chk("held_store_resp", 32'(m_valid), 32'd1);
        e_is_store = 1'b0; e_addr = 32'h30; e_rd = 5'd18;
        chk("held_resp_busy", 32'(e_ready), 32'd0);
        @(posedge clk); #1;
        chk("held_idle_ready", 32'(e_ready), 32'd1);
        chk("held_idle_quiet", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        e_valid = 1'b0;
        chk("held_accepted", 32'(e_ready), 32'd0);
        @(posedge clk); #1;
        chk("held_load_valid", 32'(m_valid), 32'd1);
        chk("held_load_rdata", m_rdata,      32'h0BADF00D);
        chk("held_load_rd",    32'(m_rd),    32'd18);
        chk("held_load_we",    32'(m_rd_we), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
